median_window_stream: RTL and testbench

MEDIAN_WINDOW_STREAM -- requirements
Module: median_window_stream

---
 rtl/median_window_stream.sv | 113 +++++++++++
 tb/tb_median_window_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/median_window_stream.sv
// Streaming 3-tap median filter with a valid/ready interface on both sides.
// Optional macro MEDIAN_ZERO_PAD_EN: emit a median on every accept, using zero-filled window slots.
module median_window_stream #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high.
    // valid never waits on ready; ready depends only on clear and the output slot.
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_w0;
    logic [DATA_W-1:0] r_w1;
    logic [DATA_W-1:0] r_w2;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_accept;
    logic              w_produce;
    logic [DATA_W-1:0] w_lo_ab;
    logic [DATA_W-1:0] w_hi_ab;
    logic [DATA_W-1:0] w_mid_c;
    logic [DATA_W-1:0] w_median;

    assign in_ready    = !clear && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign o_dbg_state = r_state;

    // median(a,b,c) = max(min(a,b), min(max(a,b),c)); ties return the duplicated value
    assign w_lo_ab  = (in_data < r_w0) ? in_data : r_w0;
    assign w_hi_ab  = (in_data < r_w0) ? r_w0 : in_data;
    assign w_mid_c  = (w_hi_ab < r_w1) ? w_hi_ab : r_w1;
    assign w_median = (w_lo_ab > w_mid_c) ? w_lo_ab : w_mid_c;

`ifdef MEDIAN_ZERO_PAD_EN
    assign w_produce = w_accept;
`else
    assign w_produce = w_accept && ((r_state == FILL2) || (r_state == RUN));
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = FILL0;
        end else if (w_accept) begin
            case (r_state)
                FILL0:   w_state_nxt = FILL1;
                FILL1:   w_state_nxt = FILL2;
                FILL2:   w_state_nxt = RUN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w0 <= '0;
            r_w1 <= '0;
            r_w2 <= '0;
        end else if (clear) begin
            r_w0 <= '0;
            r_w1 <= '0;
            r_w2 <= '0;
        end else if (w_accept) begin
            r_w2 <= r_w1;
            r_w1 <= r_w0;
            r_w0 <= in_data;
        end
    end

    // A fresh median takes precedence over a consume, giving one result per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
        end else if (w_produce) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_median;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_window_stream.sv
// Directed bench for median_window_stream with hand-computed expected medians.
module tb_median_window_stream;

    localparam int DATA_W = 4;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        o_dbg_state;

    int total = 0;
    int bad   = 0;

    median_window_stream #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .o_dbg_state (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample with the given out_ready, take the edge, then idle in_valid.
    task automatic push(input logic [DATA_W-1:0] d, input logic ordy);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = ordy;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_state", o_dbg_state, 0);
        #9 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

`ifdef MEDIAN_ZERO_PAD_EN
        push(4'd9, 1'b1);
        chk("zp_first_valid", out_valid, 1);
        chk("zp_first_data", out_data, 0);
        push(4'd9, 1'b1);
        chk("zp_second_valid", out_valid, 1);
        chk("zp_second_data", out_data, 9);
        push(4'd3, 1'b1);
        chk("zp_third_data", out_data, 9);
        push(4'd1, 1'b1);
        chk("zp_fourth_data", out_data, 3);
`else
        // 5,1,9 -> first median 5 after the third accept
        push(4'd5, 1'b1);
        chk("fill1_valid", out_valid, 0);
        chk("fill1_state", o_dbg_state, 1);
        push(4'd1, 1'b1);
        chk("fill2_valid", out_valid, 0);
        chk("fill2_state", o_dbg_state, 2);
        push(4'd9, 1'b1);
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 5);
        chk("run_state", o_dbg_state, 3);

        // back-to-back 3,3 -> 3,3 with out_valid held
        push(4'd3, 1'b1);
        chk("b2b0_valid", out_valid, 1);
        chk("b2b0_data", out_data, 3);
        push(4'd3, 1'b1);
        chk("b2b1_valid", out_valid, 1);
        chk("b2b1_data", out_data, 3);
        push(4'd9, 1'b1);
        chk("m_933_data", out_data, 3);
        push(4'd5, 1'b1);
        chk("m_593_data", out_data, 5);

        // downstream stall: 4 cycles of out_ready=0 with 12 offered
        in_valid  = 1'b1;
        in_data   = 4'd12;
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 5);
            chk("stall_in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("unstall_data", out_data, 9);
        chk("unstall_valid", out_valid, 1);
        tick();
        chk("drain_valid", out_valid, 0);

        // clear flush: drops the offered 6 and restarts the fill
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_state", o_dbg_state, 0);
        push(4'd4, 1'b1);
        push(4'd8, 1'b1);
        chk("pre_clear_state", o_dbg_state, 2);
        chk("pre_clear_valid", out_valid, 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd6;
        #1;
        chk("clear_in_ready", in_ready, 0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear2_state", o_dbg_state, 0);
        chk("clear2_valid", out_valid, 0);
        push(4'd2, 1'b1);
        chk("after_clear_s1", o_dbg_state, 1);
        push(4'd15, 1'b1);
        chk("after_clear_valid", out_valid, 0);
        push(4'd0, 1'b1);
        chk("after_clear_valid2", out_valid, 1);
        chk("after_clear_data", out_data, 2);
        tick();
        chk("single_median", out_valid, 0);

        // tie handling: {7,0,15}=7, {7,7,0}=7, {2,7,7}=7
        push(4'd7, 1'b1);
        chk("tie0_data", out_data, 7);
        push(4'd7, 1'b1);
        chk("tie1_data", out_data, 7);
        push(4'd2, 1'b1);
        chk("tie2_data", out_data, 7);
        chk("tie2_valid", out_valid, 1);

        // async reset mid-cycle with a pending median
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_state", o_dbg_state, 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        push(4'd1, 1'b1);
        chk("arst_fill1_valid", out_valid, 0);
        push(4'd1, 1'b1);
        chk("arst_fill2_valid", out_valid, 0);
        push(4'd1, 1'b1);
        chk("arst_med_valid", out_valid, 1);
        chk("arst_med_data", out_data, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
